// File: rtl/vga_frame_reader_if.sv
// vga_frame_reader_if: byte-addressed combinational read port between the VGA frame reader
// (master, drives the address) and the data memory (slave, returns the read data).
interface vga_frame_reader_if;
  logic [31:0] avga;
  logic [31:0] rdvga;

  modport master (output avga, input  rdvga);
  modport slave  (input  avga, output rdvga);
endinterface

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: VGA timing generator that fetches an 8-bit grayscale image from memory
// and upscales it by 2^SCALE_SH. Define VGA_TESTPATTERN_EN to add a colour-bar test_mode input.
module vga_frame_reader #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned IMG_W    = 25,
  parameter int unsigned IMG_H    = 25,
  parameter int unsigned IMG_BASE = 0,
  parameter int unsigned IMG_X0   = 120,
  parameter int unsigned IMG_Y0   = 40,
  parameter int unsigned SCALE_SH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  vga_frame_reader_if.master        mem,
`ifdef VGA_TESTPATTERN_EN
  input  logic                      test_mode,
`endif
  output logic                      vga_clk,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      blank_n,
  output logic                      sync_n,
  output logic [7:0]                r,
  output logic [7:0]                g,
  output logic [7:0]                b,
  output logic                      frame_done
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HcW    = $clog2(HTotal);
  localparam int unsigned VcW    = $clog2(VTotal);

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [HcW-1:0]  HcLast  = HcW'(HTotal - 1);
  localparam logic [VcW-1:0]  VcLast  = VcW'(VTotal - 1);

  localparam logic [31:0] HsStart = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HsEnd   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VsStart = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VsEnd   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] ImgXEnd = 32'(IMG_X0 + (IMG_W << SCALE_SH));
  localparam logic [31:0] ImgYEnd = 32'(IMG_Y0 + (IMG_H << SCALE_SH));

  logic            tick;
  logic [DivW-1:0] div_q, div_d;
  logic [HcW-1:0]  hc_q, hc_d;
  logic [VcW-1:0]  vc_q, vc_d;

  // Pipe stage 1: decoded position and the fetch address
  logic            act_q, act_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            img_q, img_d;
  logic [31:0]     avga_q, avga_d;
`ifdef VGA_TESTPATTERN_EN
  localparam int unsigned BarW = H_ACTIVE / 8;
  logic [2:0]      bar_q, bar_d;
`endif

  // Pipe stage 2: DAC outputs
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            blank_q, blank_d;
  logic [7:0]      r_q, r_d;
  logic [7:0]      g_q, g_d;
  logic [7:0]      b_q, b_d;

  logic [31:0]     hc32, vc32, dx, dy;
  logic [7:0]      pix;
  logic            unused_rdvga;

  // Gated by rst_n so vga_clk stays low in reset even when CLK_DIV is 1
  assign tick = (div_q == DivLast) && rst_n;

  always_comb begin
    div_d = div_q;
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (tick) begin
      div_d = '0;
      if (hc_q == HcLast) begin
        hc_d = '0;
        vc_d = (vc_q == VcLast) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  assign hc32 = 32'(hc_q);
  assign vc32 = 32'(vc_q);
  assign dx   = hc32 - IMG_X0;
  assign dy   = vc32 - IMG_Y0;

  always_comb begin
    act_d  = act_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    img_d  = img_q;
    avga_d = avga_q;
`ifdef VGA_TESTPATTERN_EN
    bar_d  = bar_q;
`endif
    if (tick) begin
      act_d  = (hc32 < H_ACTIVE) && (vc32 < V_ACTIVE);
      hs_d   = !((hc32 >= HsStart) && (hc32 < HsEnd));
      vs_d   = !((vc32 >= VsStart) && (vc32 < VsEnd));
      img_d  = act_d && (hc32 >= IMG_X0) && (hc32 < ImgXEnd) &&
               (vc32 >= IMG_Y0) && (vc32 < ImgYEnd);
      // dx/dy only feed the address when the window check has passed
      avga_d = img_d ? IMG_BASE + (dy >> SCALE_SH) * IMG_W + (dx >> SCALE_SH) : IMG_BASE;
`ifdef VGA_TESTPATTERN_EN
      bar_d  = 3'(hc32 / BarW);
`endif
    end
  end

  assign pix          = mem.rdvga[7:0];
  assign unused_rdvga = ^mem.rdvga[31:8];

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    blank_d = blank_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    if (tick) begin
      hsync_d = hs_q;
      vsync_d = vs_q;
      blank_d = act_q;
      r_d     = img_q ? pix : 8'h00;
      g_d     = img_q ? pix : 8'h00;
      b_d     = img_q ? pix : 8'h00;
`ifdef VGA_TESTPATTERN_EN
      if (test_mode && act_q) begin
        r_d = {8{bar_q[2]}};
        g_d = {8{bar_q[1]}};
        b_d = {8{bar_q[0]}};
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      hc_q    <= '0;
      vc_q    <= '0;
      act_q   <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      img_q   <= 1'b0;
      avga_q  <= IMG_BASE;
`ifdef VGA_TESTPATTERN_EN
      bar_q   <= '0;
`endif
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      r_q     <= 8'h00;
      g_q     <= 8'h00;
      b_q     <= 8'h00;
    end else begin
      div_q   <= div_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      act_q   <= act_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      img_q   <= img_d;
      avga_q  <= avga_d;
`ifdef VGA_TESTPATTERN_EN
      bar_q   <= bar_d;
`endif
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign mem.avga   = avga_q;
  assign vga_clk    = tick;
  assign frame_done = tick && (hc_q == HcLast) && (vc_q == VcLast);
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign blank_n    = blank_q;
  assign sync_n     = 1'b0;
  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: reduced-timing bench; a tick-index model predicts every output on
// every cycle, with literal pins at chosen screen positions and random resets/memory writes.
module tb_vga_frame_reader;
  localparam int unsigned D    = 2;
  localparam int unsigned HA   = 40, HFP = 4, HS = 6, HBP = 6;
  localparam int unsigned VA   = 30, VFP = 2, VS = 2, VBP = 3;
  localparam int unsigned HT   = HA + HFP + HS + HBP;   // 56
  localparam int unsigned VT   = VA + VFP + VS + VBP;   // 37
  localparam int unsigned FT   = HT * VT;               // ticks per frame
  localparam int unsigned IW   = 5, IH = 4, BASE = 3, X0 = 8, Y0 = 6, SH = 2;
  localparam int          NP   = 22;

  typedef struct {
    int x; int y; int fr; int a; int rgb; int hs; int vs; int bl;
  } pin_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vga_clk, hsync, vsync, blank_n, sync_n, frame_done;
  logic [7:0] r, g, b;
  logic [7:0] mem [256];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   started = 1'b0;
  bit   edge_rst = 1'b0;
  bit   pins_on = 1'b0;
  bit   fd_valid = 1'b0;
  int   last_fd = 0;
  pin_t pins [NP];
  int   pin_hits [NP];

  vga_frame_reader_if mif ();
  assign mif.rdvga = (mif.avga < 32'd256) ? {24'd0, mem[mif.avga[7:0]]} : 32'd0;

  vga_frame_reader #(
    .CLK_DIV (D),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .IMG_W   (IW), .IMG_H(IH), .IMG_BASE(BASE),
    .IMG_X0  (X0), .IMG_Y0(Y0), .SCALE_SH(SH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem       (mif),
`ifdef VGA_TESTPATTERN_EN
    .test_mode (1'b0),
`endif
    .vga_clk   (vga_clk),
    .hsync     (hsync),
    .vsync     (vsync),
    .blank_n   (blank_n),
    .sync_n    (sync_n),
    .r         (r),
    .g         (g),
    .b         (b),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t cyc=%0d got=%0h exp=%0h", nm, $time, cyc, act, exp);
    end
  endtask

  function automatic bit img_f(int unsigned x, int unsigned y);
    return (x < HA) && (y < VA) && (x >= X0) && (x < X0 + IW * (1 << SH)) &&
           (y >= Y0) && (y < Y0 + IH * (1 << SH));
  endfunction

  function automatic int unsigned addr_f(int unsigned x, int unsigned y);
    if (!img_f(x, y)) return BASE;
    return BASE + ((y - Y0) / (1 << SH)) * IW + (x - X0) / (1 << SH);
  endfunction

  // Cycle index since the last reset edge; cycle 0 is the first with rst_n released
  always @(posedge clk) begin
    started  <= 1'b1;
    edge_rst <= !rst_n;
    cyc      <= rst_n ? cyc + 1 : 0;
  end

  always @(negedge clk) begin
    int k, t2, x, y, ax, ay, a;
    logic [7:0] e;
    if (started) begin
      if (!rst_n) begin
        fd_valid = 1'b0;
        if (edge_rst) begin
          chk("rst_vga_clk", 32'(vga_clk), 32'd0);
          chk("rst_frame_done", 32'(frame_done), 32'd0);
          chk("rst_avga", mif.avga, BASE);
          chk("rst_sync", {29'd0, hsync, vsync, blank_n}, 32'b110);
          chk("rst_rgb", {8'd0, r, g, b}, 32'd0);
        end
      end else begin
        k = cyc / D;
        chk("vga_clk", 32'(vga_clk), 32'((cyc % D) == D - 1));
        chk("frame_done", 32'(frame_done), 32'(((cyc % D) == D - 1) && ((k % FT) == FT - 1)));
        chk("sync_n", 32'(sync_n), 32'd0);
        if (k >= 1) begin
          ax = ((k - 1) % FT) % HT;
          ay = ((k - 1) % FT) / HT;
          chk("avga", mif.avga, addr_f(ax, ay));
        end else begin
          chk("avga", mif.avga, BASE);
        end
        if (k >= 2) begin
          t2 = (k - 2) % FT;
          x  = t2 % HT;
          y  = t2 / HT;
          a  = addr_f(x, y);
          e  = img_f(x, y) ? mem[a[7:0]] : 8'h00;
          chk("hsync", 32'(hsync), 32'(!(x >= HA + HFP && x < HA + HFP + HS)));
          chk("vsync", 32'(vsync), 32'(!(y >= VA + VFP && y < VA + VFP + VS)));
          chk("blank_n", 32'(blank_n), 32'(x < HA && y < VA));
          chk("rgb", {8'd0, r, g, b}, {8'd0, e, e, e});
        end else begin
          chk("sync_early", {29'd0, hsync, vsync, blank_n}, 32'b110);
          chk("rgb_early", {8'd0, r, g, b}, 32'd0);
        end
        if (pins_on) begin
          for (int i = 0; i < NP; i++) begin
            a = pins[i].fr * FT + pins[i].y * HT + pins[i].x;
            if (k - 1 == a) chk($sformatf("pin%0d_avga", i), mif.avga, pins[i].a);
            if (k - 2 == a) begin
              pin_hits[i]++;
              e = 8'(pins[i].rgb);
              chk($sformatf("pin%0d_rgb", i), {8'd0, r, g, b}, {8'd0, e, e, e});
              chk($sformatf("pin%0d_sync", i), {29'd0, hsync, vsync, blank_n},
                  32'(pins[i].hs * 4 + pins[i].vs * 2 + pins[i].bl));
            end
          end
        end
        if (frame_done) begin
          if (fd_valid) chk("frame_period", 32'(cyc - last_fd), D * FT);
          last_fd  = cyc;
          fd_valid = 1'b1;
        end
      end
    end
  end

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < target + 100) begin
      @(negedge clk);
      n++;
    end
    if (cyc < target) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc got=%0d exp=%0d", cyc, target);
    end
  endtask

  task automatic wait_vblank();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rst_n && ((cyc / D) % FT) / HT >= VA + 1) && n < 2 * D * FT);
    if (n >= 2 * D * FT) begin
      checks++;
      errors++;
      $display("FAIL vblank_wait got=timeout exp=vblank");
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 256; n++) mem[n] = 8'(n);
    for (int i = 0; i < NP; i++) pin_hits[i] = 0;
    pins[0]  = '{43, 0, 0, 3, 0, 1, 1, 0};
    pins[1]  = '{44, 0, 0, 3, 0, 0, 1, 0};
    pins[2]  = '{49, 0, 0, 3, 0, 0, 1, 0};
    pins[3]  = '{50, 0, 0, 3, 0, 1, 1, 0};
    pins[4]  = '{7, 6, 0, 3, 0, 1, 1, 1};
    pins[5]  = '{8, 6, 0, 3, 3, 1, 1, 1};
    pins[6]  = '{12, 6, 0, 4, 4, 1, 1, 1};
    pins[7]  = '{28, 6, 0, 3, 0, 1, 1, 1};
    pins[8]  = '{11, 9, 0, 3, 3, 1, 1, 1};
    pins[9]  = '{16, 10, 0, 10, 10, 1, 1, 1};
    pins[10] = '{8, 21, 0, 18, 18, 1, 1, 1};
    pins[11] = '{27, 21, 0, 22, 22, 1, 1, 1};
    pins[12] = '{8, 22, 0, 3, 0, 1, 1, 1};
    pins[13] = '{39, 29, 0, 3, 0, 1, 1, 1};
    pins[14] = '{40, 29, 0, 3, 0, 1, 1, 0};
    pins[15] = '{0, 31, 0, 3, 0, 1, 1, 0};
    pins[16] = '{0, 32, 0, 3, 0, 1, 0, 0};
    pins[17] = '{0, 33, 0, 3, 0, 1, 0, 0};
    pins[18] = '{0, 34, 0, 3, 0, 1, 1, 0};
    pins[19] = '{16, 10, 1, 10, 255, 1, 1, 1};
    pins[20] = '{19, 13, 1, 10, 255, 1, 1, 1};
    pins[21] = '{20, 10, 1, 11, 11, 1, 1, 1};

    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    pins_on = 1'b1;

    // Live update in frame 0 vertical blank; visible from frame 1 on
    wait_cyc(D * 32 * HT);
    mem[10] = 8'hFF;
    wait_cyc(2 * D * FT + 40);
    pins_on = 1'b0;

    // Reset held for 5 clocks mid-frame
    repeat (700) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    wait_vblank();
    for (int n = 0; n < 256; n++) mem[n] = 8'($urandom);

    repeat (3) begin
      repeat ($urandom_range(200, D * FT)) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_vblank();
      repeat (4) mem[$urandom_range(0, 255)] = 8'($urandom);
    end

    repeat (D * FT + 100) @(negedge clk);
    for (int i = 0; i < NP; i++) chk($sformatf("pin%0d_reached", i), 32'(pin_hits[i] > 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
